uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have port clk_RX, input, 1 bit: single receive clock, oversampling at Prescale x baud.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port RX_IN, input, 1 bit: serial line, idle high.
REQ-004 SHALL have port PAR_EN, input, 1 bit: parity bit present in frame.
REQ-005 SHALL have port Prescale, input, 6 bits: oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port Strt_glitch, input, 1 bit: start checker result, valid one cycle after strt_chk_en.
REQ-007 SHALL have port Par_err, input, 1 bit: parity checker result, valid one cycle after par_chk_en.
REQ-008 SHALL have port Stop_Error, input, 1 bit: stop checker result, valid one cycle after stp_chk_en.
REQ-009 SHALL have port dat_samp_en, output, 1 bit: sampler enable, high in every state except IDLE.
REQ-010 SHALL have port edge_cnt, output, 6 bits: oversample index within the current bit.
REQ-011 SHALL have port strt_chk_en, par_chk_en and stp_chk_en, outputs, 1 bit each: single-cycle checker strobes.
REQ-012 SHALL have port deser_en, output, 1 bit: single-cycle strobe that shifts one data bit.
REQ-013 SHALL have port data_valid, output, 1 bit: single-cycle pulse when a frame is accepted.
REQ-014 SHALL have port frame_err, output, 1 bit: single-cycle pulse when a frame is rejected by the parity or stop check.

Function
REQ-015 SHALL define CHK_EDGE = Prescale/2 + 2, the edge at which majority sampling is complete.
REQ-016 SHALL latch Prescale on the IDLE->START transition and hold it for the whole frame; changes mid-frame are ignored.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP with binary encoding.
REQ-018 SHALL move from IDLE to START on the first cycle RX_IN=0; edge_cnt=0 in the first START cycle.
REQ-019 SHALL increment edge_cnt every non-IDLE cycle and wrap it to 0 after latched Prescale-1; each wrap ends one bit.
REQ-020 SHALL assert the state's strobe for exactly one cycle at edge_cnt==CHK_EDGE: strt_chk_en in START, deser_en in DATA, par_chk_en in PARITY, stp_chk_en in STOP.
REQ-021 In START, at edge_cnt==CHK_EDGE+1 with Strt_glitch=1, SHALL return to IDLE, clear counters and raise no error.
REQ-022 In START, at the bit end, SHALL go to DATA with bit_cnt=0.
REQ-023 In DATA, SHALL increment the 3-bit bit_cnt at each bit end; at the end of bit 7, SHALL go to PARITY if PAR_EN=1, else to STOP.
REQ-024 SHALL sample PAR_EN on entry to DATA; changes mid-frame are ignored.
REQ-025 In PARITY, at edge_cnt==CHK_EDGE+1, SHALL capture Par_err into a sticky par_flag; at the bit end, SHALL go to STOP.
REQ-026 In STOP, at edge_cnt==CHK_EDGE+1, SHALL pulse data_valid if par_flag=0 and Stop_Error=0, else pulse frame_err; SHALL go to IDLE in the same cycle.
REQ-027 The early return to IDLE in REQ-026 is required: back-to-back frames with a start bit directly after the stop bit SHALL be received without loss.
REQ-028 data_valid and frame_err SHALL never be high together.
REQ-029 SHALL clear par_flag on every IDLE->START transition.
REQ-030 SHALL treat an RX_IN low level during DATA, PARITY or STOP as data, not as a new start bit.

Reset
REQ-031 While rst=1, SHALL hold state=IDLE, edge_cnt=0, bit_cnt=0, par_flag=0 and every output 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no data_valid or frame_err pulse; the first frame after release SHALL be received normally.

Structure
REQ-033 A shared package uart_rx_pkg SHALL hold the state enumeration, CHK_EDGE offset constant, DATA_BITS=8 and the legal Prescale constants.
REQ-034 Edge and bit counting SHALL live in one sub-module, edge_bit_counter, driven by enable/clear from the FSM.

Verification
REQ-035 Prescale=8, PAR_EN=0, byte 0xA5 with valid stop -> 8 deser_en pulses, one data_valid at STOP edge 7, frame_err never asserted.
REQ-036 Prescale=16, PAR_EN=1, Par_err forced 1 in PARITY -> frame_err pulse once, data_valid stays 0.
REQ-037 Prescale=8, RX_IN low for 3 cycles then high (Strt_glitch=1) -> FSM returns to IDLE at START edge 7, no deser_en pulses.
REQ-038 Prescale=32, two back-to-back frames 0x00 then 0xFF -> two data_valid pulses, no missed start bit.
REQ-039 Stop_Error=1 on the stop check -> single frame_err pulse, FSM in IDLE on the next cycle.
REQ-040 rst pulsed during DATA bit 4 -> all outputs 0 immediately, no pulses; a following frame 0x3C -> data_valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  // Majority sampling finishes two edges past the bit centre.
  localparam logic [5:0] CHK_OFFSET = 6'd2;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic [5:0] chk_edge(input logic [5:0] presc);
    return (presc >> 1) + CHK_OFFSET;
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter (wraps every bit) and data-bit index counter.
module edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic                 clk_RX,
  input  logic                 rst,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  input  logic                 bit_inc,
  input  logic                 bit_clr,
  input  logic [5:0]           prescale,
  output logic [5:0]           edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 bit_end
);

  assign bit_end = (edge_cnt == prescale - 6'd1);

  always_ff @(posedge clk_RX or posedge rst) begin
    if (rst)          edge_cnt <= '0;
    else if (cnt_clr) edge_cnt <= '0;
    else if (cnt_en)  edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
  end

  always_ff @(posedge clk_RX or posedge rst) begin
    if (rst)          bit_cnt <= '0;
    else if (bit_clr) bit_cnt <= '0;
    else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: sequences start/data/parity/stop bits and
// strobes the external sampler, deserializer and checkers.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic       clk_RX,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       Strt_glitch,
  input  logic       Par_err,
  input  logic       Stop_Error,
  output logic       dat_samp_en,
  output logic [5:0] edge_cnt,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       frame_err
);

  rx_state_t state, state_nx;

  logic [5:0]           presc_q;
  logic                 par_en_q;
  logic                 par_flag;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 bit_end;
  logic                 cnt_en, cnt_clr, bit_inc, bit_clr;
  logic [5:0]           chk;
  logic                 at_chk, at_res;

  assign chk    = chk_edge(presc_q);
  assign at_chk = (edge_cnt == chk);
  assign at_res = (edge_cnt == chk + 6'd1);

  edge_bit_counter u_cnt (
    .clk_RX   (clk_RX),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .bit_inc  (bit_inc),
    .bit_clr  (bit_clr),
    .prescale (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk_RX or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      presc_q  <= PRESCALE_8;
      par_en_q <= 1'b0;
      par_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == START) begin
        presc_q  <= Prescale;
        par_flag <= 1'b0;
      end
      if (state == START && state_nx == DATA)
        par_en_q <= PAR_EN;
      if (state == PARITY && at_res && Par_err)
        par_flag <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_en      = (state != IDLE);
    cnt_clr     = 1'b0;
    bit_inc     = 1'b0;
    bit_clr     = 1'b0;
    dat_samp_en = (state != IDLE);
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    deser_en    = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
        if (!RX_IN) state_nx = START;
      end
      START: begin
        strt_chk_en = at_chk;
        // Glitch verdict wins over the bit end (they coincide at Prescale=8).
        if (at_res && Strt_glitch) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
          bit_clr  = 1'b1;
        end else if (bit_end) begin
          state_nx = DATA;
          bit_clr  = 1'b1;
        end
      end
      DATA: begin
        deser_en = at_chk;
        if (bit_end) begin
          bit_inc = 1'b1;
          if (bit_cnt == LAST_BIT) state_nx = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_chk_en = at_chk;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        stp_chk_en = at_chk;
        // Leave before the stop bit ends so a following start bit is not missed.
        if (at_res) begin
          data_valid = !par_flag && !Stop_Error;
          frame_err  = par_flag || Stop_Error;
          state_nx   = IDLE;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_clr  = 1'b1;
        bit_clr  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames, reassembles the byte
// on deser_en and scores each frame end against a queue of expectations.
module tb_uart_rx_fsm;

  logic       clk_RX = 1'b0;
  logic       rst, RX_IN, PAR_EN, Strt_glitch, Par_err, Stop_Error;
  logic [5:0] Prescale;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       deser_en, data_valid, frame_err;
  logic [5:0] edge_cnt;

  always #5 clk_RX = ~clk_RX;

  uart_rx_fsm dut (
    .clk_RX      (clk_RX),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .Strt_glitch (Strt_glitch),
    .Par_err     (Par_err),
    .Stop_Error  (Stop_Error),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  typedef struct {
    bit       err;
    bit [7:0] data;
    int       p;
    bit       pe;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0, errors = 0;
  int       deser_n = 0, strt_n = 0, par_n = 0, stp_n = 0;
  int       tot_deser = 0, tot_strt = 0, tot_end = 0;
  logic [7:0] shreg = '0;
  bit       just_ended = 0;
  logic     last_samp = 1'b0;
  logic [5:0] last_edge = '0;
  int       snap_deser, snap_strt, snap_end;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {dat_samp_en, edge_cnt, strt_chk_en, par_chk_en, stp_chk_en,
            deser_en, data_valid, frame_err};
  endfunction

  task automatic sample();
    exp_t e;
    if (just_ended) begin
      chk("idle_after_end", {25'd0, dat_samp_en, edge_cnt}, 32'd0);
      just_ended = 0;
    end
    last_samp = dat_samp_en;
    last_edge = edge_cnt;
    if (data_valid || frame_err)
      chk("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    if (strt_chk_en) begin
      strt_n = 1; deser_n = 0; par_n = 0; stp_n = 0; tot_strt++;
    end
    if (deser_en) begin
      shreg = {RX_IN, shreg[7:1]};
      deser_n++; tot_deser++;
    end
    if (par_chk_en) par_n++;
    if (stp_chk_en) stp_n++;
    if (data_valid || frame_err) begin
      tot_end++;
      just_ended = 1;
      if (sb.size() == 0) begin
        chk("unexpected_frame_end", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("end_is_frame_err", {31'd0, frame_err}, {31'd0, e.err});
        if (!e.err) chk("rx_byte", {24'd0, shreg}, {24'd0, e.data});
        chk("end_edge", {26'd0, edge_cnt}, 32'(e.p / 2 + 3));
        chk("deser_pulses", 32'(deser_n), 32'd8);
        chk("par_chk_pulses", 32'(par_n), {31'd0, e.pe});
        chk("stp_chk_pulses", 32'(stp_n), 32'd1);
        chk("strt_chk_pulses", 32'(strt_n), 32'd1);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_RX);
      sample();
      @(posedge clk_RX);
      #1;
    end
  endtask

  task automatic send(input bit [7:0] d, input int p, input bit pe, input bit err);
    exp_t e;
    e.err = err; e.data = d; e.p = p; e.pe = pe;
    sb.push_back(e);
    Prescale = 6'(p);
    PAR_EN   = pe;
    RX_IN    = 1'b0;
    step(p);
    Prescale = (p == 8) ? 6'd32 : 6'd8;
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      if (i == 2) PAR_EN = ~pe;
      step(p);
    end
    if (pe) begin
      RX_IN = ^d;
      step(p);
    end
    RX_IN = 1'b1;
    step(p);
  endtask

  initial begin
    rst = 1'b1; RX_IN = 1'b0; PAR_EN = 1'b0; Prescale = 6'd8;
    Strt_glitch = 1'b0; Par_err = 1'b0; Stop_Error = 1'b0;
    @(posedge clk_RX); #1;
    step(3);
    chk("reset_outputs", {19'd0, outs()}, 32'd0);
    RX_IN = 1'b1;
    rst = 1'b0;
    step(3);
    chk("idle_after_release", {19'd0, outs()}, 32'd0);

    // 8x, no parity
    send(8'hA5, 8, 1'b0, 1'b0);
    step(4);
    chk("sb_empty_a5", 32'(sb.size()), 32'd0);

    // 16x, parity error forced
    Par_err = 1'b1;
    send(8'h5A, 16, 1'b1, 1'b1);
    step(4);
    Par_err = 1'b0;
    chk("sb_empty_parerr", 32'(sb.size()), 32'd0);

    // parity flag must not leak into the next frame
    send(8'h81, 16, 1'b1, 1'b0);
    step(4);
    chk("sb_empty_par_ok", 32'(sb.size()), 32'd0);

    // start glitch: 3 low cycles, checker reports glitch
    snap_deser = tot_deser; snap_strt = tot_strt; snap_end = tot_end;
    Strt_glitch = 1'b1;
    Prescale = 6'd8;
    RX_IN = 1'b0;
    step(3);
    RX_IN = 1'b1;
    step(6);
    chk("glitch_start_edge7", {25'd0, last_samp, last_edge}, {25'd0, 1'b1, 6'd7});
    step(1);
    chk("glitch_back_idle", {25'd0, last_samp, last_edge}, 32'd0);
    step(20);
    Strt_glitch = 1'b0;
    chk("glitch_no_deser", 32'(tot_deser), 32'(snap_deser));
    chk("glitch_one_strt", 32'(tot_strt), 32'(snap_strt + 1));
    chk("glitch_no_end", 32'(tot_end), 32'(snap_end));

    // 32x back-to-back frames
    snap_end = tot_end;
    send(8'h00, 32, 1'b0, 1'b0);
    send(8'hFF, 32, 1'b0, 1'b0);
    step(4);
    chk("b2b_two_ends", 32'(tot_end), 32'(snap_end + 2));
    chk("sb_empty_b2b", 32'(sb.size()), 32'd0);

    // stop error
    Stop_Error = 1'b1;
    send(8'hC3, 16, 1'b0, 1'b1);
    step(4);
    Stop_Error = 1'b0;
    chk("sb_empty_stoperr", 32'(sb.size()), 32'd0);

    // reset during data bit 4, then a clean frame
    snap_end = tot_end;
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    step(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = ~RX_IN;
      step(8);
    end
    RX_IN = 1'b0;
    step(3);
    chk("pre_reset_busy", {31'd0, dat_samp_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_async_outputs", {19'd0, outs()}, 32'd0);
    step(2);
    chk("reset_held_outputs", {19'd0, outs()}, 32'd0);
    RX_IN = 1'b1;
    rst = 1'b0;
    step(4);
    chk("reset_no_end", 32'(tot_end), 32'(snap_end));
    send(8'h3C, 8, 1'b0, 1'b0);
    step(4);
    chk("post_reset_frame", 32'(tot_end), 32'(snap_end + 1));
    chk("sb_empty_final", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
